// File: rtl/mem_access_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_if
// Purpose  : CPU-side bus bundle for the memory access unit (loads, strobes,
//            MAR/MDR views and status pulses).
// Revision : 1.0 - initial release
// ============================================================================
interface mem_access_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9
);
    logic [DATA_W-1:0] BusMuxOut;
    logic              MARin;
    logic              MDRin;
    logic              read_mem;
    logic              write_mem;
    logic [DATA_W-1:0] MDR;
    logic [ADDR_W-1:0] MAR;
    logic              busy;
    logic              done;
    logic              err;

    modport master (
        output BusMuxOut, MARin, MDRin, read_mem, write_mem,
        input  MDR, MAR, busy, done, err
    );

    modport slave (
        input  BusMuxOut, MARin, MDRin, read_mem, write_mem,
        output MDR, MAR, busy, done, err
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MAR/MDR register pair with a wait-stated on-chip word memory.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 9,
    parameter int DEPTH       = 512,
    parameter int WAIT_STATES = 1
) (
    input  wire logic      clk,
    input  wire logic      reset,
    mem_access_if.slave    bus
);
    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]        C_WAIT  = 4'(WAIT_STATES);
    localparam logic [ADDR_W:0]   C_DEPTH = (ADDR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] mar_q,   mar_d;
    logic [DATA_W-1:0] mdr_q,   mdr_d;
    logic [3:0]        cnt_q,   cnt_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              done_q,  done_d;
    logic              err_q,   err_d;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              mem_we;
    logic              in_range;
    logic [DATA_W-1:0] mem_rdata;

    always_comb begin
        state_d  = state_q;
        mar_d    = mar_q;
        mdr_d    = mdr_q;
        cnt_d    = cnt_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        mem_we   = 1'b0;
        in_range = ({1'b0, addr_q} < C_DEPTH);
        mem_rdata = in_range ? mem_q[addr_q[IDX_W-1:0]] : '0;

        unique case (state_q)
            IDLE: begin
                if (bus.MARin) mar_d = bus.BusMuxOut[ADDR_W-1:0];
                if (bus.MDRin) mdr_d = bus.BusMuxOut;
                // The access captures MAR/MDR as they will look after this edge
                if (bus.read_mem && bus.write_mem) begin
                    err_d = 1'b1;
                end else if (bus.read_mem) begin
                    addr_d  = mar_d;
                    cnt_d   = C_WAIT;
                    state_d = RD_WAIT;
                end else if (bus.write_mem) begin
                    addr_d  = mar_d;
                    wdata_d = mdr_d;
                    cnt_d   = C_WAIT;
                    state_d = WR_WAIT;
                end
            end
            RD_WAIT, WR_WAIT: begin
                if (bus.read_mem || bus.write_mem) err_d = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    if (state_q == RD_WAIT) mdr_d = mem_rdata;
                    else                    mem_we = in_range;
                    done_d  = 1'b1;
                    err_d   = err_d | ~in_range;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Reset wins over a commit landing on the same edge
        if (reset) mem_we = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            mar_q   <= '0;
            mdr_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mar_q   <= mar_d;
            mdr_q   <= mdr_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Memory contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q[IDX_W-1:0]] <= wdata_q;
    end

    assign bus.MAR  = mar_q;
    assign bus.MDR  = mdr_q;
    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_unit
// Purpose  : Directed self-checking bench: a wait-stated, 256-word unit and a
//            zero-wait unit exercised through their bus interfaces.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_unit;
    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    int   n_done;

    mem_access_if #(.DATA_W(32), .ADDR_W(9)) a_if ();
    mem_access_if #(.DATA_W(32), .ADDR_W(9)) b_if ();

    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(256), .WAIT_STATES(2)) u_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    mem_access_unit #(.DATA_W(32), .ADDR_W(9), .DEPTH(512), .WAIT_STATES(0)) u_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
            $error("check %s did not match", tag);
        end
    endtask

    // Full write or read on unit A: load MAR, load MDR, strobe, wait for done
    task automatic acc_a(input string tag, input logic [8:0] addr,
                         input logic [31:0] data, input bit wr);
        bit seen;
        a_if.BusMuxOut = {23'd0, addr}; a_if.MARin = 1'b1; cyc(); a_if.MARin = 1'b0;
        a_if.BusMuxOut = data;          a_if.MDRin = 1'b1; cyc(); a_if.MDRin = 1'b0;
        if (wr) a_if.write_mem = 1'b1; else a_if.read_mem = 1'b1;
        cyc();
        a_if.write_mem = 1'b0; a_if.read_mem = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            cyc();
            seen = a_if.done;
        end
        check({tag, "_done"}, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        n_cmp = 0; n_err = 0; n_done = 0;
        reset = 1'b1;
        a_if.BusMuxOut = '0; a_if.MARin = 0; a_if.MDRin = 0; a_if.read_mem = 0; a_if.write_mem = 0;
        b_if.BusMuxOut = '0; b_if.MARin = 0; b_if.MDRin = 0; b_if.read_mem = 0; b_if.write_mem = 0;
        cyc(); cyc();
        reset = 1'b0;
        check("rst_mar",  {23'd0, a_if.MAR}, 32'd0);
        check("rst_mdr",  a_if.MDR, 32'd0);
        check("rst_busy", {31'd0, a_if.busy}, 32'd0);
        check("rst_done", {31'd0, a_if.done}, 32'd0);
        check("rst_err",  {31'd0, a_if.err},  32'd0);

        // Write 0xDEADBEEF to address 5 with two wait states
        a_if.BusMuxOut = 32'h5; a_if.MARin = 1; cyc(); a_if.MARin = 0;
        check("wr_mar", {23'd0, a_if.MAR}, 32'h5);
        a_if.BusMuxOut = 32'hDEADBEEF; a_if.MDRin = 1; cyc(); a_if.MDRin = 0;
        check("wr_mdr", a_if.MDR, 32'hDEADBEEF);
        a_if.write_mem = 1; cyc(); a_if.write_mem = 0;
        check("wr_busy1", {31'd0, a_if.busy}, 32'd1);
        cyc();
        check("wr_busy2", {31'd0, a_if.busy}, 32'd1);
        cyc();
        check("wr_busy3", {31'd0, a_if.busy}, 32'd1);
        check("wr_nodone", {31'd0, a_if.done}, 32'd0);
        cyc();
        check("wr_idle", {31'd0, a_if.busy}, 32'd0);
        check("wr_done", {31'd0, a_if.done}, 32'd1);
        check("wr_err",  {31'd0, a_if.err},  32'd0);
        cyc();
        check("wr_done_end", {31'd0, a_if.done}, 32'd0);

        // Read back address 5 after clearing MDR
        a_if.BusMuxOut = 32'h0; a_if.MDRin = 1; cyc(); a_if.MDRin = 0;
        check("rd_clr", a_if.MDR, 32'h0);
        a_if.read_mem = 1; cyc(); a_if.read_mem = 0;
        cyc(); cyc();
        check("rd_early", a_if.MDR, 32'h0);
        cyc();
        check("rd_done", {31'd0, a_if.done}, 32'd1);
        check("rd_data", a_if.MDR, 32'hDEADBEEF);
        check("rd_err",  {31'd0, a_if.err}, 32'd0);

        // Both strobes in IDLE
        a_if.read_mem = 1; a_if.write_mem = 1; cyc(); a_if.read_mem = 0; a_if.write_mem = 0;
        check("col_err",  {31'd0, a_if.err},  32'd1);
        check("col_busy", {31'd0, a_if.busy}, 32'd0);
        cyc();
        check("col_err_end", {31'd0, a_if.err}, 32'd0);

        // Write strobe during an active read
        a_if.BusMuxOut = 32'h0; a_if.MDRin = 1; cyc(); a_if.MDRin = 0;
        a_if.read_mem = 1; cyc(); a_if.read_mem = 0;
        a_if.write_mem = 1; cyc(); a_if.write_mem = 0;
        check("bsy_err",  {31'd0, a_if.err},  32'd1);
        check("bsy_busy", {31'd0, a_if.busy}, 32'd1);
        cyc();
        check("bsy_err_end", {31'd0, a_if.err}, 32'd0);
        cyc();
        check("bsy_done", {31'd0, a_if.done}, 32'd1);
        check("bsy_data", a_if.MDR, 32'hDEADBEEF);
        check("bsy_mar",  {23'd0, a_if.MAR}, 32'h5);

        // Out-of-range accesses on the 256-word unit
        acc_a("seed_f0", 9'h0F0, 32'hCAFEF00D, 1'b1);
        a_if.BusMuxOut = 32'h1111_11F0; a_if.MARin = 1; a_if.MDRin = 1; cyc();
        a_if.MARin = 0; a_if.MDRin = 0;
        check("oor_mar", {23'd0, a_if.MAR}, 32'h1F0);
        check("oor_mdr", a_if.MDR, 32'h1111_11F0);
        a_if.read_mem = 1; cyc(); a_if.read_mem = 0;
        cyc(); cyc(); cyc();
        check("oor_rd_done", {31'd0, a_if.done}, 32'd1);
        check("oor_rd_err",  {31'd0, a_if.err},  32'd1);
        check("oor_rd_mdr",  a_if.MDR, 32'h0);
        acc_a("oor_wr", 9'h1F0, 32'h2222_2222, 1'b1);
        check("oor_wr_err", {31'd0, a_if.err}, 32'd1);
        acc_a("chk_f0", 9'h0F0, 32'h0, 1'b0);
        check("chk_f0_data", a_if.MDR, 32'hCAFEF00D);
        check("chk_f0_err",  {31'd0, a_if.err}, 32'd0);

        // Reset one cycle into a write at address 7
        acc_a("seed_7", 9'h007, 32'h0BADF00D, 1'b1);
        a_if.BusMuxOut = 32'h7; a_if.MARin = 1; cyc(); a_if.MARin = 0;
        a_if.BusMuxOut = 32'h1234; a_if.MDRin = 1; cyc(); a_if.MDRin = 0;
        a_if.write_mem = 1; cyc(); a_if.write_mem = 0;
        reset = 1; cyc(); reset = 0;
        check("abt_mar",  {23'd0, a_if.MAR}, 32'd0);
        check("abt_mdr",  a_if.MDR, 32'd0);
        check("abt_busy", {31'd0, a_if.busy}, 32'd0);
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (a_if.done) n_done++;
        end
        check("abt_nodone", n_done, 32'd0);
        acc_a("chk_7", 9'h007, 32'h0, 1'b0);
        check("chk_7_data", a_if.MDR, 32'h0BADF00D);

        // Zero-wait unit: same-edge load+write, then back-to-back reads
        b_if.BusMuxOut = 32'h5A5A_5A03; b_if.MARin = 1; b_if.MDRin = 1; b_if.write_mem = 1;
        cyc();
        b_if.MARin = 0; b_if.MDRin = 0; b_if.write_mem = 0;
        check("b_wr_busy", {31'd0, b_if.busy}, 32'd1);
        check("b_wr_mar",  {23'd0, b_if.MAR}, 32'h003);
        cyc();
        check("b_wr_done", {31'd0, b_if.done}, 32'd1);
        check("b_wr_idle", {31'd0, b_if.busy}, 32'd0);
        b_if.BusMuxOut = 32'h0; b_if.MDRin = 1; b_if.read_mem = 1; cyc();
        b_if.MDRin = 0; b_if.read_mem = 0;
        check("b_rd1_busy", {31'd0, b_if.busy}, 32'd1);
        check("b_rd1_mdr0", b_if.MDR, 32'h0);
        check("b_rd1_nodone", {31'd0, b_if.done}, 32'd0);
        cyc();
        check("b_rd1_done", {31'd0, b_if.done}, 32'd1);
        check("b_rd1_data", b_if.MDR, 32'h5A5A_5A03);
        b_if.read_mem = 1; cyc(); b_if.read_mem = 0;
        check("b_rd2_busy", {31'd0, b_if.busy}, 32'd1);
        check("b_rd2_gap",  {31'd0, b_if.done}, 32'd0);
        check("b_rd2_err",  {31'd0, b_if.err},  32'd0);
        cyc();
        check("b_rd2_done", {31'd0, b_if.done}, 32'd1);
        check("b_rd2_data", b_if.MDR, 32'h5A5A_5A03);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter DATA_W, default 32, the width of data words, MDR and the bus.
REQ-002 Parameter ADDR_W, default 9, the width of MAR and the memory address.
REQ-003 Parameter DEPTH, default 512, the number of memory words; the unit SHALL require DEPTH <= 2^ADDR_W.
REQ-004 Parameter WAIT_STATES, default 1, the number of extra cycles added to each access; the unit SHALL require 0 <= WAIT_STATES <= 15.
REQ-005 clk  input  1  is the single clock; all state SHALL change on its rising edge.
REQ-006 reset  input  1  is a synchronous, active-high reset.
REQ-007 BusMuxOut  input  DATA_W  is the CPU bus value.
REQ-008 MARin  input  1  loads MAR from BusMuxOut[ADDR_W-1:0].
REQ-009 MDRin  input  1  loads MDR from BusMuxOut.
REQ-010 read_mem  input  1  is a one-cycle strobe that starts a memory read at MAR.
REQ-011 write_mem  input  1  is a one-cycle strobe that starts a memory write of MDR to MAR.
REQ-012 MDR  output  DATA_W  is the current MDR contents.
REQ-013 MAR  output  ADDR_W  is the current MAR contents.
REQ-014 busy  output  1  is high while an access is in progress.
REQ-015 done  output  1  is a one-cycle pulse marking access completion.
REQ-016 err  output  1  is a one-cycle pulse marking a rejected or out-of-range request.

Function
REQ-017 The unit SHALL implement states IDLE, RD_WAIT, WR_WAIT and a down-counter cnt that is 4 bits wide.
REQ-018 In IDLE, MARin SHALL load MAR and MDRin SHALL load MDR on the same edge; if both are asserted, both registers SHALL load.
REQ-019 In RD_WAIT and WR_WAIT, MARin and MDRin SHALL be ignored, so MAR and MDR hold their values.
REQ-020 In IDLE with read_mem=1 and write_mem=0, the unit SHALL latch the access address from MAR, as updated by any MARin on the same edge, set cnt=WAIT_STATES, and enter RD_WAIT.
REQ-021 In IDLE with write_mem=1 and read_mem=0, the unit SHALL latch the address and the write data from MAR and MDR, each as updated on the same edge, set cnt=WAIT_STATES, and enter WR_WAIT.
REQ-022 busy SHALL be 1 exactly when the state is RD_WAIT or WR_WAIT.
REQ-023 In a WAIT state with cnt>0, the unit SHALL decrement cnt.
REQ-024 In RD_WAIT with cnt==0, the unit SHALL load MDR from mem[addr], pulse done, and return to IDLE.
REQ-025 In WR_WAIT with cnt==0, the unit SHALL write mem[addr] with the latched data, pulse done, and return to IDLE.
REQ-026 Latency: if a strobe is sampled on edge N, done SHALL be high during the cycle after edge N+WAIT_STATES+1, and the MDR update SHALL be visible on that same edge.
REQ-027 With WAIT_STATES=0, busy SHALL last one cycle and done SHALL follow it on the next edge.
REQ-028 A new strobe SHALL be accepted in the same cycle that done is high, because the state is IDLE in that cycle.
REQ-029 read_mem and write_mem asserted together in IDLE SHALL start no access, leave the state in IDLE, and pulse err.
REQ-030 Any strobe asserted while busy SHALL be ignored, leave the current access unaffected, and pulse err.
REQ-031 If the latched addr >= DEPTH, the access SHALL still take the full latency; a read SHALL load MDR with 0, a write SHALL leave memory unchanged, and err SHALL pulse together with done.
REQ-032 Memory reads and writes SHALL occur only at cnt==0 completion; nothing SHALL be committed earlier.

Reset
REQ-033 On reset, the unit SHALL set state=IDLE, MAR=0, MDR=0, cnt=0, busy=0, done=0 and err=0.
REQ-034 Reset SHALL NOT clear memory contents.
REQ-035 Reset asserted during RD_WAIT or WR_WAIT SHALL abort the access; no write SHALL commit and no done SHALL be produced.
REQ-036 Reset SHALL take priority over all strobe inputs and all load inputs on the same edge.

Verification
REQ-037 Bench scenario (WAIT_STATES=2, write): MARin with bus=0x05, then MDRin with bus=0xDEADBEEF, then write_mem -> busy high for 3 cycles, then one cycle of done, and mem[5]=0xDEADBEEF.
REQ-038 Bench scenario (read-back): clear MDR to 0, then read_mem at MAR=5 -> MDR=0xDEADBEEF on the done cycle, 3 cycles after the strobe, with err=0.
REQ-039 Bench scenario (collisions): read_mem together with write_mem in IDLE -> err pulses with busy=0; then write_mem during an active read -> err pulses and the read still completes with the correct data.
REQ-040 Bench scenario (DEPTH=256, ADDR_W=9): read at MAR=0x1F0 -> MDR=0 and done and err pulse together; a write at 0x1F0 leaves mem[0xF0] unchanged.
REQ-041 Bench scenario (mid-operation reset): reset one cycle after write_mem at MAR=7 with MDR=0x1234 -> MAR=0, MDR=0, busy=0, mem[7] keeps its prior value, and no done pulse.
REQ-042 Bench scenario (WAIT_STATES=0, back-to-back): two reads are accepted on consecutive done cycles -> two done pulses that are 2 cycles apart.
